half_exp_prescale: RTL and testbench

//  Upstream stage of the half-precision base-2 exponent path: computes y = a * log2(e) in IEEE-754 binary16.

---
 rtl/half_exp_prescale.sv | 203 ++++++++++++++++++++
 tb/tb_half_exp_prescale.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/half_exp_prescale.sv
// half_exp_prescale: computes y = a * SCALE in IEEE-754 binary16 (SCALE = log2(e) by default).
// Feeding y into half_base2_exp yields e^a. Three-stage pipeline, fixed latency 3, no backpressure.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears every valid flag and data register
//   in_valid   a is valid this cycle
//   a[31:0]    [15:0] binary16 operand, [31:16] ignored
//   out_valid  c is valid this cycle
//   c[31:0]    [15:0] binary16 result, [31:16] always 0; holds while out_valid is low
//
// Build option: define PRESCALE_SUBNORMAL_EN to accept subnormal inputs and produce subnormal
// results. Without it, subnormal inputs are flushed to signed zero.
module half_exp_prescale #(
    parameter int unsigned BITS  = 16,
    parameter logic [16:0] SCALE = 17'h17154
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] a,
    output logic        out_valid,
    output logic [31:0] c
);

    logic [BITS-1:0] op;
    logic            unused_hi;
    assign op        = a[BITS-1:0];
    assign unused_hi = ^a[31:BITS];

    // ---------------- S1: unpack / classify ----------------
    logic        s1_nan, s1_inf, s1_zero;
    logic [6:0]  s1_exp;   // unbiased exponent, two's complement
    logic [10:0] s1_man;   // {hidden, fraction}
    logic [4:0]  ex;
    logic [9:0]  fr;

    assign ex = op[14:10];
    assign fr = op[9:0];

`ifdef PRESCALE_SUBNORMAL_EN
    logic [3:0] lz;
    always_comb begin
        lz = 4'd0;
        // Last hit wins, so lz reflects the most significant set bit.
        for (int i = 0; i < 10; i++) begin
            if (fr[i]) lz = 4'(9 - i);
        end
    end
`endif

    always_comb begin
        s1_nan  = (ex == 5'h1F) && (fr != 10'd0);
        s1_inf  = (ex == 5'h1F) && (fr == 10'd0);
        s1_zero = 1'b0;
        s1_exp  = {2'b00, ex} - 7'd15;
        s1_man  = {1'b1, fr};
        if (ex == 5'h1F) begin
            s1_exp = 7'd0;
            s1_man = 11'd0;
        end else if (ex == 5'd0) begin
`ifdef PRESCALE_SUBNORMAL_EN
            if (fr == 10'd0) begin
                s1_zero = 1'b1;
                s1_exp  = 7'd0;
                s1_man  = 11'd0;
            end else begin
                // Value is 0.fr * 2^-14; shift the leading one into the hidden position.
                s1_man = {1'b0, fr} << (lz + 4'd1);
                s1_exp = 7'h71 - {3'b000, lz};  // -15 - lz
            end
`else
            s1_zero = 1'b1;
            s1_exp  = 7'd0;
            s1_man  = 11'd0;
`endif
        end
    end

    logic        v1_q, sgn1_q, nan1_q, inf1_q, zero1_q;
    logic [6:0]  exp1_q;
    logic [10:0] man1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q    <= 1'b0;
            sgn1_q  <= 1'b0;
            nan1_q  <= 1'b0;
            inf1_q  <= 1'b0;
            zero1_q <= 1'b0;
            exp1_q  <= 7'd0;
            man1_q  <= 11'd0;
        end else begin
            v1_q    <= in_valid;
            sgn1_q  <= op[15];
            nan1_q  <= s1_nan;
            inf1_q  <= s1_inf;
            zero1_q <= s1_zero;
            exp1_q  <= s1_exp;
            man1_q  <= s1_man;
        end
    end

    // ---------------- S2: multiply ----------------
    logic        v2_q, sgn2_q, nan2_q, inf2_q, zero2_q;
    logic [6:0]  exp2_q;
    logic [27:0] prod2_q;  // binary point at bit 26, value in [1,4)

    always_ff @(posedge clk) begin
        if (reset) begin
            v2_q    <= 1'b0;
            sgn2_q  <= 1'b0;
            nan2_q  <= 1'b0;
            inf2_q  <= 1'b0;
            zero2_q <= 1'b0;
            exp2_q  <= 7'd0;
            prod2_q <= 28'd0;
        end else begin
            v2_q    <= v1_q;
            sgn2_q  <= sgn1_q;
            nan2_q  <= nan1_q;
            inf2_q  <= inf1_q;
            zero2_q <= zero1_q;
            exp2_q  <= exp1_q;
            prod2_q <= 28'(man1_q) * 28'(SCALE);
        end
    end

    // ---------------- S3: normalise / round / pack ----------------
    logic        top;
    logic [7:0]  exp_n, biased, eff, eff_m1;
    logic [26:0] q, q_sh;
    logic        st0, lost, grd, stk, rnd;
    logic [10:0] sig;
    logic [11:0] sum;
    logic [16:0] enc;
    logic [15:0] res;

`ifdef PRESCALE_SUBNORMAL_EN
    logic       denorm;
    logic [7:0] sh;
    logic [53:0] sh_full;
`endif

    always_comb begin
        top    = prod2_q[27];
        exp_n  = {exp2_q[6], exp2_q} + {7'd0, top};
        q      = top ? prod2_q[27:1] : prod2_q[26:0];
        st0    = top & prod2_q[0];
        biased = exp_n + 8'd15;
`ifdef PRESCALE_SUBNORMAL_EN
        // Below the normal range: shift right so the quantum is 2^-24, keep lost bits as sticky.
        denorm  = biased[7] || (biased == 8'd0);
        sh      = denorm ? (8'd1 - biased) : 8'd0;
        sh_full = {q, 27'd0} >> sh;
        q_sh    = sh_full[53:27];
        lost    = |sh_full[26:0];
        eff     = denorm ? 8'd1 : biased;
`else
        q_sh    = q;
        lost    = 1'b0;
        eff     = biased;
`endif
        sig    = q_sh[26:16];
        grd    = q_sh[15];
        stk    = (|q_sh[14:0]) | lost | st0;
        rnd    = grd & (stk | sig[0]);
        sum    = {1'b0, sig} + {11'd0, rnd};
        eff_m1 = eff - 8'd1;
        // Adding the hidden-bit-inclusive significand lets a rounding carry bump the exponent
        // field (and turns a rounded-up subnormal into 0x0400) without a separate path.
        enc    = {eff_m1[6:0], 10'd0} + {5'd0, sum};

        if (nan2_q) begin
            res = 16'h7E00;
        end else if (inf2_q) begin
            res = {sgn2_q, 15'h7C00};
        end else if (zero2_q) begin
            res = {sgn2_q, 15'h0000};
        end else if (enc >= 17'h07C00) begin
            res = {sgn2_q, 15'h7C00};
        end else begin
            res = {sgn2_q, enc[14:0]};
        end
    end

    logic        v3_q;
    logic [15:0] c_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            v3_q <= 1'b0;
            c_q  <= 16'd0;
        end else begin
            v3_q <= v2_q;
            if (v2_q) c_q <= res;
        end
    end

    assign out_valid = v3_q;
    assign c         = {16'd0, c_q};

endmodule

// File: tb/tb_half_exp_prescale.sv
module tb_half_exp_prescale;

    localparam int MaxCyc = 2000;

    logic        clk = 1'b0;
    logic        reset, in_valid;
    logic [31:0] a;
    logic        out_valid, out_valid_id;
    logic [31:0] c, c_id;

    always #5 clk = ~clk;

    half_exp_prescale u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .a         (a),
        .out_valid (out_valid),
        .c         (c)
    );

    half_exp_prescale #(.SCALE(17'h10000)) u_id (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .a         (a),
        .out_valid (out_valid_id),
        .c         (c_id)
    );

    int          n_vec  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic        hist_v   [MaxCyc];
    logic        hist_clr [MaxCyc];
    logic [15:0] hist_c   [MaxCyc];
    logic [15:0] hist_ci  [MaxCyc];
    logic [15:0] exp_c  = 16'd0;
    logic [15:0] exp_ci = 16'd0;

    // Exact product m*scale*2^k rounded to binary16 with round-to-nearest-even.
    function automatic logic [15:0] ref_model(input logic [15:0] x, input longint scale);
        logic   s;
        int     e, eu, b, xe, qe, k, field;
        longint f, mu, p, units, rem, half;
        s = x[15];
        e = int'(x[14:10]);
        f = longint'(x[9:0]);
        if (e == 31) return (f != 0) ? 16'h7E00 : {s, 15'h7C00};
        if (e == 0 && f == 0) return {s, 15'h0000};
`ifndef PRESCALE_SUBNORMAL_EN
        if (e == 0) return {s, 15'h0000};
`endif
        if (e == 0) begin
            mu = f;
            eu = -24;
        end else begin
            mu = f + 1024;
            eu = e - 25;
        end
        // value = p * 2^(eu-16)
        p = mu * scale;
        b = 0;
        for (int i = 0; i < 40; i++) if (p[i]) b = i;
        xe = b + eu - 16;
        qe = (xe - 10 < -24) ? -24 : xe - 10;
        k  = qe - (eu - 16);
        units = p >> k;
        rem   = p - (units << k);
        half  = longint'(1) << (k - 1);
        if (rem > half || (rem == half && units[0])) units = units + 1;
        if (units == 2048) begin
            units = 1024;
            qe    = qe + 1;
        end
        if (units < 1024) return {s, 5'd0, units[9:0]};
        field = qe + 25;
        if (field > 30) return {s, 15'h7C00};
        return {s, 5'(field), units[9:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want)
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: got %h, want %h", tag, cyc, got, want);
        end
    endtask

    // One clock cycle: check what emerges now (input from 3 cycles ago), then drive new inputs.
    task automatic step(input logic rst, input logic v, input logic [31:0] av);
        int   j;
        logic norm;
        @(negedge clk);
        if (cyc >= 3) begin
            j = cyc - 3;
            if (hist_clr[j]) begin
                exp_c  = 16'd0;
                exp_ci = 16'd0;
            end
            if (hist_v[j]) begin
                exp_c  = hist_c[j];
                exp_ci = hist_ci[j];
            end
            check("out_valid",    {31'd0, out_valid},    {31'd0, hist_v[j]});
            check("c",            c,                     {16'd0, exp_c});
            check("out_valid_id", {31'd0, out_valid_id}, {31'd0, hist_v[j]});
            check("c_id",         c_id,                  {16'd0, exp_ci});
        end
        reset    = rst;
        in_valid = v;
        a        = av;
        norm     = (av[14:10] != 5'd0) && (av[14:10] != 5'h1F);
        hist_v[cyc]   = v & ~rst;
        hist_clr[cyc] = rst;
        hist_c[cyc]   = ref_model(av[15:0], 64'h17154);
        hist_ci[cyc]  = norm ? av[15:0] : ref_model(av[15:0], 64'h10000);
        if (rst) begin
            for (int d = 1; d <= 2; d++) begin
                if (cyc - d >= 0) begin
                    hist_v[cyc-d]   = 1'b0;
                    hist_clr[cyc-d] = 1'b1;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [15:0] op;
        int          issued;
        reset    = 1'b1;
        in_valid = 1'b0;
        a        = 32'd0;

        // Reset, with in_valid high to show reset dominates.
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h0000_3C00);
        step(1'b1, 1'b0, 32'd0);
        idle(3);

        // Single pulse of 1.0
        step(1'b0, 1'b1, 32'h0000_3C00);
        idle(3);

        // Back-to-back operands, upper half garbage
        step(1'b0, 1'b1, 32'hA5A5_4000);
        step(1'b0, 1'b1, 32'h1234_BC00);
        step(1'b0, 1'b1, 32'hFFFF_0000);
        step(1'b0, 1'b1, 32'h0F0F_8000);
        idle(3);

        // Specials and overflow
        step(1'b0, 1'b1, 32'h0000_7C00);
        step(1'b0, 1'b1, 32'h0000_FC00);
        step(1'b0, 1'b1, 32'h0000_7E01);
        step(1'b0, 1'b1, 32'h0000_7BFF);
        step(1'b0, 1'b1, 32'h0000_FBFF);
        step(1'b0, 1'b1, 32'h0000_FE00);
        idle(3);

        // Subnormals, including the largest and smallest
        step(1'b0, 1'b1, 32'h0000_0200);
        step(1'b0, 1'b1, 32'h0000_83FF);
        step(1'b0, 1'b1, 32'h0000_0001);
        step(1'b0, 1'b1, 32'h0000_0400);
        idle(3);

        // Reset one cycle after a burst of three: only the first survives
        step(1'b0, 1'b1, 32'h0000_3555);
        step(1'b0, 1'b1, 32'h0000_C123);
        step(1'b0, 1'b1, 32'h0000_1234);
        step(1'b1, 1'b1, 32'h0000_3C00);
        idle(5);

        // Random normal operands with occasional bubbles
        issued = 0;
        while (issued < 1000) begin
            r = $urandom();
            if ($urandom_range(0, 4) == 0) begin
                step(1'b0, 1'b0, r);
            end else begin
                op = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)),
                      10'($urandom_range(0, 1023))};
                step(1'b0, 1'b1, {r[31:16], op});
                issued++;
            end
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
